// File: rtl/cache_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cache_access_sequencer
// Purpose  : Upstream read-request generator for the direct-mapped data
//            cache. Issues ACCESS_COUNT sequential word reads from
//            START_ADDR, one outstanding at a time, counts hits, then
//            computes hit_rate = floor(hit_count*100/ACCESS_COUNT) with a
//            serial restoring divider and raises done.
// Ports    : clk          - clock, rising edge
//            rst          - asynchronous reset, active-low
//            cache_ready  - cache finished the current read
//            cache_hit    - hit flag, qualified by cache_ready
//            cache_read   - one-cycle read request pulse
//            cache_write  - constant 0 (read-only workload)
//            address      - word address, stable from request to ready
//            hit_count    - hits counted so far
//            hit_rate     - percent 0..100, valid when done=1
//            done         - run finished, held until reset
// Revision : 1.0 - initial release
// ============================================================================
module cache_access_sequencer #(
  parameter int ADDR_WIDTH   = 15,
  parameter int START_ADDR   = 1024,
  parameter int ACCESS_COUNT = 8192,
  parameter int CNT_WIDTH    = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cache_ready,
  input  logic                  cache_hit,
  output logic                  cache_read,
  output logic                  cache_write,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [6:0]            hit_rate,
  output logic                  done
);

  localparam int NUM_W = CNT_WIDTH + 7;
  localparam int BIT_W = $clog2(NUM_W + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_MUL   = 3'd3;
  localparam logic [2:0] S_DIV   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  localparam logic [CNT_WIDTH:0]    DIVISOR   = (CNT_WIDTH+1)'(ACCESS_COUNT);
  localparam logic [BIT_W-1:0]      LAST_BIT  = BIT_W'(NUM_W - 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_INIT = ADDR_WIDTH'(START_ADDR);

  logic [2:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_WIDTH-1:0]  acc_q, acc_d;
  logic [CNT_WIDTH-1:0]  hit_q, hit_d;
  logic [NUM_W-1:0]      num_q, num_d;   // dividend, shifts into quotient
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [6:0]            rate_q, rate_d;

  logic [CNT_WIDTH:0]    w_acc_inc;
  logic                  w_last;
  logic [CNT_WIDTH:0]    w_trial;
  logic                  w_ge;
  logic [CNT_WIDTH-1:0]  w_trial_sub;
  logic [NUM_W-1:0]      w_num_shift;

  assign w_acc_inc = {1'b0, acc_q} + 1'b1;
  assign w_last    = (w_acc_inc == DIVISOR);

  // One restoring step: bring the next dividend bit into the remainder and
  // subtract the divisor when it fits. Only the low CNT_WIDTH bits of the
  // difference are needed since the remainder always stays below DIVISOR.
  assign w_trial     = {rem_q, num_q[NUM_W-1]};
  assign w_ge        = (w_trial >= DIVISOR);
  assign w_trial_sub = w_trial[CNT_WIDTH-1:0] - DIVISOR[CNT_WIDTH-1:0];
  assign w_num_shift = {num_q[NUM_W-2:0], w_ge};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; cache_ready only matters in WAIT
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT:  if (cache_ready) state_d = w_last ? S_MUL : S_ISSUE;
      S_MUL:   state_d = S_DIV;
      S_DIV:   if (bit_q == LAST_BIT) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    cache_read  = (state_q == S_ISSUE);
    cache_write = 1'b0;
    done        = (state_q == S_DONE);
  end

  assign address   = addr_q;
  assign hit_count = hit_q;
  assign hit_rate  = rate_q;

  // Datapath next-state
  always_comb begin
    addr_d = addr_q;
    acc_d  = acc_q;
    hit_d  = hit_q;
    num_d  = num_q;
    rem_d  = rem_q;
    bit_d  = bit_q;
    rate_d = rate_q;
    case (state_q)
      S_WAIT: begin
        if (cache_ready) begin
          acc_d = w_acc_inc[CNT_WIDTH-1:0];
          hit_d = hit_q + CNT_WIDTH'(cache_hit);
          if (!w_last) addr_d = addr_q + 1'b1;
        end
      end
      S_MUL: begin
        num_d = NUM_W'(hit_q) * NUM_W'(100);
        rem_d = '0;
        bit_d = '0;
      end
      S_DIV: begin
        num_d = w_num_shift;
        rem_d = w_ge ? w_trial_sub : w_trial[CNT_WIDTH-1:0];
        bit_d = bit_q + 1'b1;
        if (bit_q == LAST_BIT) rate_d = w_num_shift[6:0];
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= ADDR_INIT;
      acc_q  <= '0;
      hit_q  <= '0;
      num_q  <= '0;
      rem_q  <= '0;
      bit_q  <= '0;
      rate_q <= '0;
    end else begin
      addr_q <= addr_d;
      acc_q  <= acc_d;
      hit_q  <= hit_d;
      num_q  <= num_d;
      rem_q  <= rem_d;
      bit_q  <= bit_d;
      rate_q <= rate_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cache_access_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_access_sequencer
// Purpose  : Self-checking bench for cache_access_sequencer. A cache
//            responder answers each read after a fixed or random delay and
//            a reference model tracks the expected address order, hit total
//            and percentage. A second instance runs a 3-access configuration.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cache_access_sequencer;

  logic clk = 1'b0;
  logic rst0_n, rst1_n;
  logic cache_ready, cache_hit;
  logic sel;

  logic        rd0, wr0, done0, rd1, wr1, done1;
  logic [14:0] addr0, addr1;
  logic [13:0] hc0, hc1;
  logic [6:0]  hr0, hr1;

  logic        m_rd, m_wr, m_done;
  logic [14:0] m_addr;

  int n_checks = 0;
  int n_fail   = 0;

  // observations gathered by the responder
  int          n_reads, addr_errs, extra_reads, unstable, write_seen;
  int          exp_hits, last_ready_cyc, done_cyc;
  bit          timed_out;
  logic [14:0] last_addr;

  always #5 clk = ~clk;

  cache_access_sequencer u_dut0 (
    .clk(clk), .rst(rst0_n), .cache_ready(cache_ready), .cache_hit(cache_hit),
    .cache_read(rd0), .cache_write(wr0), .address(addr0), .hit_count(hc0),
    .hit_rate(hr0), .done(done0)
  );

  cache_access_sequencer #(
    .ADDR_WIDTH(15), .START_ADDR(0), .ACCESS_COUNT(3), .CNT_WIDTH(14)
  ) u_dut1 (
    .clk(clk), .rst(rst1_n), .cache_ready(cache_ready), .cache_hit(cache_hit),
    .cache_read(rd1), .cache_write(wr1), .address(addr1), .hit_count(hc1),
    .hit_rate(hr1), .done(done1)
  );

  assign m_rd   = sel ? rd1   : rd0;
  assign m_wr   = sel ? wr1   : wr0;
  assign m_done = sel ? done1 : done0;
  assign m_addr = sel ? addr1 : addr0;

  // Cache hit behaviour for each scenario
  function automatic logic hit_of(input int mode, input logic [14:0] a);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return (a[1:0] != 2'b00);
      default: return (a == 15'd1);
    endcase
  endfunction

  // Cache responder and reference model. Runs until done, a cycle budget,
  // or (if abort_reads>0) the WAIT phase of read number abort_reads.
  task automatic drive_run(input int start, input int hmode, input bit rnd,
                           input int abort_reads, input int max_cyc);
    int          wait_left = 0;
    bit          pending   = 0;
    logic [14:0] req       = '0;
    int          cyc       = 0;
    n_reads = 0; addr_errs = 0; extra_reads = 0; unstable = 0;
    write_seen = 0; exp_hits = 0; last_ready_cyc = 0; done_cyc = 0;
    timed_out = 0; last_addr = '0;
    while (1) begin
      @(negedge clk);
      cyc++;
      if (cyc > max_cyc) begin timed_out = 1; break; end
      if (m_wr !== 1'b0) write_seen++;
      if (m_done === 1'b1) begin done_cyc = cyc; break; end
      if (m_rd === 1'b1) begin
        if (pending) extra_reads++;
        if (m_addr !== 15'(start + n_reads)) addr_errs++;
        n_reads++;
        pending   = 1;
        req       = m_addr;
        last_addr = m_addr;
        wait_left = rnd ? int'($urandom_range(0, 5)) : 0;
        // junk ready during the request cycle must be ignored
        cache_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        cache_hit   = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      end else if (pending) begin
        if (m_addr !== req) unstable++;
        if (abort_reads != 0 && n_reads == abort_reads) begin
          cache_ready = 1'b0;
          break;
        end
        if (wait_left == 0) begin
          cache_ready    = 1'b1;
          cache_hit      = hit_of(hmode, req);
          exp_hits      += int'(cache_hit);
          pending        = 0;
          last_ready_cyc = cyc;
        end else begin
          cache_ready = 1'b0;
          cache_hit   = 1'($urandom_range(0, 1));
          wait_left--;
        end
      end else begin
        cache_ready = 1'b0;
        cache_hit   = 1'b0;
      end
    end
    cache_ready = 1'b0;
    cache_hit   = 1'b0;
  endtask

  task automatic restart0();
    @(negedge clk); rst0_n = 1'b0;
    @(negedge clk); rst0_n = 1'b1;
  endtask

  task automatic test_reset();
    rst0_n = 1'b0; rst1_n = 1'b0; cache_ready = 1'b1; cache_hit = 1'b1; sel = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (addr0 !== 15'd1024) begin n_fail++; $display("FAIL reset.address got=%0d exp=1024", addr0); end
    n_checks++; if (rd0 !== 1'b0 || wr0 !== 1'b0) begin n_fail++; $display("FAIL reset.rd_wr got=%0b%0b exp=00", rd0, wr0); end
    n_checks++; if (hc0 !== 14'd0 || hr0 !== 7'd0) begin n_fail++; $display("FAIL reset.counts got hc=%0d hr=%0d exp=0", hc0, hr0); end
    n_checks++; if (done0 !== 1'b0) begin n_fail++; $display("FAIL reset.done got=%0b exp=0", done0); end
    n_checks++; if (addr1 !== 15'd0) begin n_fail++; $display("FAIL reset.address_small got=%0d exp=0", addr1); end
    cache_ready = 1'b0; cache_hit = 1'b0;
  endtask

  task automatic test_all_hit();
    rst0_n = 1'b1;
    drive_run(1024, 1, 0, 0, 20000);
    n_checks++; if (timed_out) begin n_fail++; $display("FAIL all_hit.timeout got=timeout exp=done"); end
    n_checks++; if (n_reads !== 8192) begin n_fail++; $display("FAIL all_hit.reads got=%0d exp=8192", n_reads); end
    n_checks++; if (addr_errs !== 0 || extra_reads !== 0) begin n_fail++; $display("FAIL all_hit.order got errs=%0d extra=%0d exp=0", addr_errs, extra_reads); end
    n_checks++; if (hc0 !== 14'(exp_hits) || exp_hits != 8192) begin n_fail++; $display("FAIL all_hit.hit_count got=%0d exp=%0d", hc0, exp_hits); end
    n_checks++; if (hr0 !== 7'(exp_hits * 100 / 8192)) begin n_fail++; $display("FAIL all_hit.hit_rate got=%0d exp=%0d", hr0, exp_hits * 100 / 8192); end
    n_checks++; if (done_cyc - last_ready_cyc != 23) begin n_fail++; $display("FAIL all_hit.latency got=%0d exp=23", done_cyc - last_ready_cyc); end
  endtask

  task automatic test_all_miss();
    restart0();
    drive_run(1024, 0, 0, 0, 20000);
    n_checks++; if (timed_out || n_reads != 8192) begin n_fail++; $display("FAIL all_miss.reads got=%0d exp=8192", n_reads); end
    n_checks++; if (hc0 !== 14'd0) begin n_fail++; $display("FAIL all_miss.hit_count got=%0d exp=0", hc0); end
    n_checks++; if (hr0 !== 7'd0) begin n_fail++; $display("FAIL all_miss.hit_rate got=%0d exp=0", hr0); end
    n_checks++; if (last_addr !== 15'd9215 || addr0 !== 15'd9215) begin n_fail++; $display("FAIL all_miss.last_addr got=%0d/%0d exp=9215", last_addr, addr0); end
    n_checks++; if (done0 !== 1'b1) begin n_fail++; $display("FAIL all_miss.done got=%0b exp=1", done0); end
  endtask

  // Random response delays with junk ready in the request cycle; hits follow
  // the address pattern (miss on word offset 0).
  task automatic test_random_handshake();
    restart0();
    drive_run(1024, 2, 1, 0, 60000);
    n_checks++; if (timed_out || n_reads != 8192) begin n_fail++; $display("FAIL rand.reads got=%0d exp=8192", n_reads); end
    n_checks++; if (addr_errs !== 0 || extra_reads !== 0) begin n_fail++; $display("FAIL rand.order got errs=%0d extra=%0d exp=0", addr_errs, extra_reads); end
    n_checks++; if (unstable !== 0) begin n_fail++; $display("FAIL rand.addr_stable got=%0d exp=0", unstable); end
    n_checks++; if (write_seen !== 0) begin n_fail++; $display("FAIL rand.cache_write got=%0d exp=0", write_seen); end
    n_checks++; if (hc0 !== 14'(exp_hits) || exp_hits != 6144) begin n_fail++; $display("FAIL rand.hit_count got=%0d exp=%0d", hc0, exp_hits); end
    n_checks++; if (hr0 !== 7'd75) begin n_fail++; $display("FAIL rand.hit_rate got=%0d exp=75", hr0); end
    n_checks++; if (done_cyc - last_ready_cyc != 23) begin n_fail++; $display("FAIL rand.latency got=%0d exp=23", done_cyc - last_ready_cyc); end
  endtask

  task automatic test_mid_reset();
    restart0();
    drive_run(1024, 1, 0, 100, 1000);
    n_checks++; if (hc0 !== 14'd99 || addr0 !== 15'd1123) begin n_fail++; $display("FAIL mid_reset.pre got hc=%0d addr=%0d exp hc=99 addr=1123", hc0, addr0); end
    #1 rst0_n = 1'b0;
    #1;
    n_checks++; if (addr0 !== 15'd1024 || hc0 !== 14'd0) begin n_fail++; $display("FAIL mid_reset.async got addr=%0d hc=%0d exp addr=1024 hc=0", addr0, hc0); end
    n_checks++; if (rd0 !== 1'b0 || done0 !== 1'b0 || hr0 !== 7'd0) begin n_fail++; $display("FAIL mid_reset.outputs got rd=%0b done=%0b hr=%0d exp 0", rd0, done0, hr0); end
    @(negedge clk); rst0_n = 1'b1;
    drive_run(1024, 1, 0, 0, 20000);
    n_checks++; if (timed_out || n_reads != 8192 || addr_errs != 0) begin n_fail++; $display("FAIL mid_reset.rerun got reads=%0d errs=%0d exp 8192/0", n_reads, addr_errs); end
    n_checks++; if (hc0 !== 14'd8192 || hr0 !== 7'd100) begin n_fail++; $display("FAIL mid_reset.result got hc=%0d hr=%0d exp 8192/100", hc0, hr0); end
  endtask

  task automatic test_small_count();
    sel = 1'b1;
    @(negedge clk); rst1_n = 1'b1;
    drive_run(0, 3, 0, 0, 200);
    n_checks++; if (timed_out || n_reads != 3 || addr_errs != 0) begin n_fail++; $display("FAIL small.reads got=%0d errs=%0d exp 3/0", n_reads, addr_errs); end
    n_checks++; if (hc1 !== 14'(exp_hits) || exp_hits != 1) begin n_fail++; $display("FAIL small.hit_count got=%0d exp=%0d", hc1, exp_hits); end
    n_checks++; if (hr1 !== 7'(exp_hits * 100 / 3)) begin n_fail++; $display("FAIL small.hit_rate got=%0d exp=%0d", hr1, exp_hits * 100 / 3); end
    n_checks++; if (done_cyc - last_ready_cyc != 23) begin n_fail++; $display("FAIL small.latency got=%0d exp=23", done_cyc - last_ready_cyc); end
    repeat (5) @(negedge clk);
    n_checks++; if (done1 !== 1'b1 || rd1 !== 1'b0 || hr1 !== 7'd33) begin n_fail++; $display("FAIL small.hold got done=%0b rd=%0b hr=%0d exp 1/0/33", done1, rd1, hr1); end
  endtask

  initial begin
    test_reset();
    test_all_hit();
    test_all_miss();
    test_random_handshake();
    test_mid_reset();
    test_small_count();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
